// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU controller slice.
// Holds opcode encodings, FSM state encoding and instruction field positions.
package alu_pkg;

    localparam int INSTR_W = 11;
    localparam int RF_N    = 4;
    localparam int RF_AW   = 2;
    localparam int IMM_W   = 4;

    // Instruction field LSB positions
    localparam int OPC_LSB  = 8;
    localparam int DST_LSB  = 6;
    localparam int SRCA_LSB = 4;
    localparam int SRCB_LSB = 2;
    localparam int IMM_LSB  = 2;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_OR    = 3'b100,
        OP_NOT_A = 3'b101,
        OP_XOR   = 3'b110,
        OP_LDI   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4-entry register file, two async read ports, a debug read
// port and one synchronous write port; async active-low reset clears all.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RF_AW-1:0]  ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [RF_AW-1:0]  rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [RF_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [RF_AW-1:0]  wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] rf [RF_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_N; i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    assign ra_data  = rf[ra_addr];
    assign rb_data  = rf[rb_addr];
    assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: three-state (IDLE/EXEC/WB) controller feeding an external ALU.
// Ports: instr valid/ready handshake, alu_* to/from ALU, wb_* write report,
// zero_flag of last write, rd_addr/rd_data debug read of the register file.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [2:0]         alu_opcode,
    output logic [DATA_W-1:0]  alu_op_a,
    output logic [DATA_W-1:0]  alu_op_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               wb_valid,
    output logic [RF_AW-1:0]   wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               zero_flag,
    input  logic [RF_AW-1:0]   rd_addr,
    output logic [DATA_W-1:0]  rd_data
);

    state_e state;
    state_e state_nx;

    op_e               dec_opc;
    logic [RF_AW-1:0]  dec_dst;
    logic [RF_AW-1:0]  dec_a;
    logic [RF_AW-1:0]  dec_b;
    logic [IMM_W-1:0]  dec_imm;
    logic              unused_pad;

    op_e               opc_q;
    logic [RF_AW-1:0]  dst_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [IMM_W-1:0]  imm_q;

    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              accept;
    logic              we;
    logic [DATA_W-1:0] wr_val;

    assign dec_opc    = op_e'(instr[OPC_LSB +: 3]);
    assign dec_dst    = instr[DST_LSB +: RF_AW];
    assign dec_a      = instr[SRCA_LSB +: RF_AW];
    assign dec_b      = instr[SRCB_LSB +: RF_AW];
    assign dec_imm    = instr[IMM_LSB +: IMM_W];
    assign unused_pad = ^instr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        alu_opcode  = '0;
        alu_op_a    = '0;
        alu_op_b    = '0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                alu_opcode = opc_q;
                alu_op_a   = a_q;
                alu_op_b   = b_q;
                state_nx   = WB;
            end
            WB: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign accept = instr_valid && instr_ready;

    // The write lands on the EXEC->WB edge, so the WB cycle reports it and
    // the next instruction (accepted no earlier than after WB) sees it.
    assign we     = (state == EXEC) && (opc_q != OP_NOP);
    assign wr_val = (opc_q == OP_LDI) ? DATA_W'(imm_q) : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q <= OP_NOP;
            dst_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
        end else if (accept) begin
            opc_q <= dec_opc;
            dst_q <= dec_dst;
            a_q   <= ra_data;
            b_q   <= rb_data;
            imm_q <= dec_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            zero_flag <= 1'b0;
        end else begin
            wb_valid <= we;
            if (we) begin
                wb_addr   <= dst_q;
                wb_data   <= wr_val;
                zero_flag <= (wr_val == '0);
            end
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (dec_a),
        .ra_data  (ra_data),
        .rb_addr  (dec_b),
        .rb_data  (rb_data),
        .dbg_addr (rd_addr),
        .dbg_data (rd_data),
        .we       (we),
        .wa       (dst_q),
        .wd       (wr_val)
    );

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed bench for alu_ctrl with a behavioural ALU and a
// scoreboard of expected register writes.
module tb_alu_ctrl;
    import alu_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [10:0]  instr = '0;
    logic [2:0]   alu_opcode;
    logic [W-1:0] alu_op_a;
    logic [W-1:0] alu_op_b;
    logic [W-1:0] alu_result;
    logic         wb_valid;
    logic [1:0]   wb_addr;
    logic [W-1:0] wb_data;
    logic         zero_flag;
    logic [1:0]   rd_addr = '0;
    logic [W-1:0] rd_data;

    alu_ctrl #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_op_a    (alu_op_a),
        .alu_op_b    (alu_op_b),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU
    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            3'b001:  alu_result = alu_op_a + alu_op_b;
            3'b010:  alu_result = alu_op_a - alu_op_b;
            3'b011:  alu_result = alu_op_a & alu_op_b;
            3'b100:  alu_result = alu_op_a | alu_op_b;
            3'b101:  alu_result = ~alu_op_a;
            3'b110:  alu_result = alu_op_a ^ alu_op_b;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic         we;
        logic [1:0]   addr;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] m_rf [4];
    logic         m_zero;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] opc, input logic [1:0] dst,
                         input logic [1:0] a, input logic [1:0] b,
                         input logic wr, input logic [W-1:0] val,
                         output int acc);
        exp_t         e;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        bit           got;
        instr       = {opc, dst, a, b, 2'b00};
        instr_valid = 1'b1;
        ea          = m_rf[a];
        eb          = m_rf[b];
        e.we        = wr;
        e.addr      = dst;
        e.data      = val;
        sb.push_back(e);
        got = 1'b0;
        acc = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (instr_ready === 1'b1) got = 1'b1;
            @(posedge clk);
            #1;
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL accept_timeout: got 0 want 1");
        end
        if (!got) return;
        acc = cyc;
        chk("exec_ready", 8'(instr_ready), 8'd0);
        chk("exec_opc", 8'(alu_opcode), 8'(opc));
        chk("exec_a", 8'(alu_op_a), 8'(ea));
        chk("exec_b", 8'(alu_op_b), 8'(eb));
        chk("exec_wbv", 8'(wb_valid), 8'd0);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wb_valid", 8'(wb_valid), 8'(e.we));
        if (e.we) begin
            chk("wb_addr", 8'(wb_addr), 8'(e.addr));
            chk("wb_data", 8'(wb_data), 8'(e.data));
            chk("wb_zero", 8'(zero_flag), 8'(e.data == '0));
            m_rf[e.addr] = e.data;
            m_zero       = (e.data == '0);
        end else begin
            chk("nop_zero", 8'(zero_flag), 8'(m_zero));
        end
        chk("wb_ready", 8'(instr_ready), 8'd0);
        chk("wb_alu_opc", 8'(alu_opcode), 8'd0);
        chk("wb_alu_a", 8'(alu_op_a), 8'd0);
        rd_addr = dst;
        @(posedge clk);
        #1;
        chk("idle_ready", 8'(instr_ready), 8'd1);
        chk("idle_wbv", 8'(wb_valid), 8'd0);
        chk("rd_data", 8'(rd_data), 8'(m_rf[dst]));
    endtask

    task automatic ldi(input logic [1:0] dst, input logic [3:0] imm,
                       output int acc);
        issue(3'b111, dst, imm[3:2], imm[1:0], 1'b1, imm, acc);
    endtask

    task automatic rd_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            chk(tag, 8'(rd_data), 8'(m_rf[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a1;
        int a2;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        m_zero = 1'b0;

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_ready", 8'(instr_ready), 8'd1);
        chk("rst_wbv", 8'(wb_valid), 8'd0);
        chk("rst_wba", 8'(wb_addr), 8'd0);
        chk("rst_wbd", 8'(wb_data), 8'd0);
        chk("rst_zero", 8'(zero_flag), 8'd0);
        rd_all("rst_rf");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LDI r1=5, then ADD r3 = r1 + r2
        ldi(2'd1, 4'd5, a1);
        chk("ldi_r1", 8'(rd_data), 8'd5);
        ldi(2'd2, 4'd3, a1);
        issue(3'b001, 2'd3, 2'd1, 2'd2, 1'b1, 4'd8, a1);

        // SUB to zero, then NOP keeps the zero flag and rf
        ldi(2'd1, 4'd3, a1);
        issue(3'b010, 2'd0, 2'd1, 2'd2, 1'b1, 4'd0, a1);
        chk("sub_zero", 8'(zero_flag), 8'd1);
        chk("nop_ready_pre", 8'(instr_ready), 8'd1);
        issue(3'b000, 2'd2, 2'd1, 2'd1, 1'b0, 4'd0, a1);
        instr_valid = 1'b0;
        chk("nop_zero_kept", 8'(zero_flag), 8'd1);
        rd_all("nop_rf");

        // Wrapping subtract
        ldi(2'd1, 4'd1, a1);
        ldi(2'd2, 4'd2, a1);
        issue(3'b010, 2'd0, 2'd1, 2'd2, 1'b1, 4'd15, a1);

        // Back-to-back LDI then NOT_A reading it
        ldi(2'd0, 4'd7, a1);
        issue(3'b101, 2'd1, 2'd0, 2'd0, 1'b1, 4'd8, a2);
        chk("b2b_gap", 8'(a2 - a1), 8'd3);
        instr_valid = 1'b0;

        // Reset during EXEC aborts the write
        @(posedge clk);
        #1;
        instr       = {3'b001, 2'd3, 2'd0, 2'd1, 2'b00};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_exec", 8'(alu_opcode), 8'd1);
        instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        chk("abort_ready", 8'(instr_ready), 8'd1);
        chk("abort_wbv", 8'(wb_valid), 8'd0);
        @(posedge clk);
        #1;
        chk("abort_wbv2", 8'(wb_valid), 8'd0);
        chk("abort_zero", 8'(zero_flag), 8'd0);
        rd_all("abort_rf");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_ready", 8'(instr_ready), 8'd1);
        chk("post_wbv", 8'(wb_valid), 8'd0);
        rd_all("post_rf");

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
